jtvigil_rom_arb: RTL
====================

Name: jtvigil_rom_arb

Overview:
- Shares one SDRAM bank (bank 0) between three byte-wide ROM requesters: main CPU ROM, sound CPU ROM and ADPCM sample ROM.
- Round-robin arbitration; one outstanding SDRAM read at a time.
- Each requester gets a registered copy of its last fetched data, plus an ok flag.
- Instantiated inside jtvigil_sdram, between the CPU/ADPCM ROM ports and the ba0_* signals.

Parameters:
- MAIN_AW, 18, main ROM byte-address width
- SND_AW, 15, sound ROM byte-address width
- PCM_AW, 17, ADPCM ROM byte-address width
- SND_OFFSET, 22'h10_0000, word offset of sound ROM in bank 0
- PCM_OFFSET, 22'h14_0000, word offset of ADPCM ROM in bank 0

Ports:
- clk  in  1  SDRAM clock
- rst  in  1  synchronous, active-high reset
- main_cs  in  1  main ROM request
- main_addr  in  MAIN_AW  main byte address
- main_data  out  8  main ROM byte
- main_ok  out  1  main_data valid for main_addr
- snd_cs / snd_addr(SND_AW) / snd_data(8) / snd_ok: same semantics, sound CPU
- pcm_cs / pcm_addr(PCM_AW) / pcm_data(8) / pcm_ok: same semantics, ADPCM
- ba_addr  out  22  SDRAM word address
- ba_rd  out  1  read request, held until ba_ack
- ba_ack  in  1  request accepted
- ba_rdy  in  1  data_read valid this cycle
- data_read  in  16  SDRAM read word

Behaviour:
- One clock (clk). Reset is synchronous and active-high on rst.
- Reset values:
  - ba_rd=0, ba_addr=0
  - all *_data=0, all *_ok=0
  - valid flags cleared
  - round-robin pointer = main
  - FSM = IDLE
- Per-requester state: valid bit, latched byte address, latched byte.
- ok = cs & valid & (latched addr == addr). ok is combinational on the registered state and drops in the same cycle addr changes or cs falls.
- Pending = cs & ~ok.
- Word address:
  - main: main_addr[MAIN_AW-1:1]
  - snd: SND_OFFSET + snd_addr[SND_AW-1:1]
  - pcm: PCM_OFFSET + pcm_addr[PCM_AW-1:1]
  - Result is zero-extended to 22 bits; the sum wraps modulo 2^22.
- Byte select: addr[0]=0 selects data_read[7:0]; addr[0]=1 selects data_read[15:8].
- FSM:
  - IDLE: if any requester is pending, grant the first pending one searching from the RR pointer (order main → snd → pcm → main). Latch its address and grant id. Next cycle: ba_rd=1, ba_addr valid, go to ACK. If nothing is pending, stay in IDLE.
  - ACK: hold ba_rd and ba_addr stable until ba_ack. On ba_ack: ba_rd=0 next cycle, go to WAIT.
  - WAIT: on ba_rdy, store the selected byte and the latched address into the granted requester, set its valid bit, set RR pointer = grant+1, go to IDLE. ok can assert the following cycle.
- Minimum latency from cs rise (IDLE) to ok: 3 cycles + SDRAM ack→rdy time.
- Boundary conditions:
  - cs falls mid-transaction: the transaction completes and its data is stored; ok stays 0 because cs=0. No abort is issued to the SDRAM.
  - addr changes mid-transaction: the stored data is tagged with the old address, so ok stays 0. The requester is re-arbitrated on the next IDLE.
  - ba_ack and ba_rdy in the same cycle while in ACK: treated as ack, then rdy; data is captured and FSM goes to IDLE directly.
  - ba_rdy seen in IDLE or ACK without a prior ack: ignored.
  - Reset mid-operation: FSM returns to IDLE and ba_rd drops next cycle. A late ba_rdy is ignored. All valid bits are cleared.
  - All three requesters pending continuously: each is served once per three transactions.

Optional Feature:
- JTVIGIL_ROMCACHE_EN defined:
  - Each requester stores the full 16-bit word and a word-address tag.
  - ok compares addr[AW-1:1] only; data is selected by the current addr[0].
  - Consecutive byte reads of the same word hit with no SDRAM access.
- Undefined:
  - Byte storage only, full byte-address compare.
  - Reading the other byte of the same word re-fetches it.

Decomposition:
- Package jtvigil_arb_pkg:
  - grant id enum: GNT_MAIN=0, GNT_SND=1, GNT_PCM=2
  - FSM state enum: IDLE, ACK, WAIT
  - default offset constants
- Sub-module jtvigil_rom_slot: per-requester valid/tag/data register plus the ok compare. Instantiated three times with width parameters.

Test Plan:
- Reset, then main_cs=1, main_addr=18'h00011; SDRAM returns 16'hBEEF → ba_addr=22'h000008; main_data=8'hBE; main_ok=1 one cycle after ba_rdy.
- snd_cs=1, snd_addr=15'h0004 → ba_addr=22'h100002; snd_ok asserts with data_read[7:0].
- main, snd and pcm cs all held high with changing addresses for 9 transactions → grant order is main, snd, pcm, repeated; no requester is served twice in a row while others are pending.
- main_addr changes 18'h00010 → 18'h00020 between ba_ack and ba_rdy → main_ok stays 0; the next ba_rd carries 22'h000010.
- rst pulsed during WAIT, then ba_rdy → no ok asserted, ba_rd=0 and FSM in IDLE after reset.
- With JTVIGIL_ROMCACHE_EN: main_addr 18'h00010 then 18'h00011 → one ba_rd total; ok is high for the second address in the same cycle the address changes.

Source files
------------

// File: rtl/jtvigil_arb_pkg.sv
// Shared types for the bank-0 ROM arbiter: grant ids, FSM states, default ROM offsets.
// No logic; grant rotation helper only.
package jtvigil_arb_pkg;

    typedef enum logic [1:0] {
        GNT_MAIN = 2'd0,
        GNT_SND  = 2'd1,
        GNT_PCM  = 2'd2
    } gnt_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        WAIT = 2'd2
    } state_e;

    localparam logic [21:0] DEF_SND_OFFSET = 22'h10_0000;
    localparam logic [21:0] DEF_PCM_OFFSET = 22'h14_0000;

    function automatic gnt_e gnt_next(input gnt_e g);
        case (g)
            GNT_MAIN: return GNT_SND;
            GNT_SND:  return GNT_PCM;
            default:  return GNT_MAIN;
        endcase
    endfunction

endpackage

// File: rtl/jtvigil_rom_slot.sv
// Per-requester fetched-data store plus hit compare (word cache when JTVIGIL_ROMCACHE_EN).
// Latency: write visible next cycle; ok/data are combinational on stored state and current addr.
module jtvigil_rom_slot #(
    parameter int AW = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    input  logic          wr,
    input  logic [AW-1:0] wr_addr,
    input  logic [15:0]   wr_word,
    output logic [7:0]    data,
    output logic          ok
);

`ifdef JTVIGIL_ROMCACHE_EN
    logic          valid_q;
    logic [AW-2:0] tag_q;
    logic [15:0]   word_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            word_q  <= '0;
        end else if (wr) begin
            valid_q <= 1'b1;
            tag_q   <= wr_addr[AW-1:1];
            word_q  <= wr_word;
        end
    end

    // Both bytes of the stored word are served, so only the word part must match.
    assign ok   = cs & valid_q & (tag_q == addr[AW-1:1]);
    assign data = addr[0] ? word_q[15:8] : word_q[7:0];
`else
    logic          valid_q;
    logic [AW-1:0] tag_q;
    logic [7:0]    byte_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            byte_q  <= '0;
        end else if (wr) begin
            valid_q <= 1'b1;
            tag_q   <= wr_addr;
            byte_q  <= wr_addr[0] ? wr_word[15:8] : wr_word[7:0];
        end
    end

    assign ok   = cs & valid_q & (tag_q == addr);
    assign data = byte_q;
`endif

endmodule

// File: rtl/jtvigil_rom_arb.sv
// Round-robin share of SDRAM bank 0 among main, sound and ADPCM ROMs; one read in flight.
// Latency: cs to ok >= 3 cycles + ack-to-rdy; ba_rd held until ba_ack. Option: JTVIGIL_ROMCACHE_EN.
module jtvigil_rom_arb
    import jtvigil_arb_pkg::*;
#(
    parameter int          MAIN_AW    = 18,
    parameter int          SND_AW     = 15,
    parameter int          PCM_AW     = 17,
    parameter logic [21:0] SND_OFFSET = DEF_SND_OFFSET,
    parameter logic [21:0] PCM_OFFSET = DEF_PCM_OFFSET
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               main_cs,
    input  logic [MAIN_AW-1:0] main_addr,
    output logic [7:0]         main_data,
    output logic               main_ok,
    input  logic               snd_cs,
    input  logic [SND_AW-1:0]  snd_addr,
    output logic [7:0]         snd_data,
    output logic               snd_ok,
    input  logic               pcm_cs,
    input  logic [PCM_AW-1:0]  pcm_addr,
    output logic [7:0]         pcm_data,
    output logic               pcm_ok,
    output logic [21:0]        ba_addr,
    output logic               ba_rd,
    input  logic               ba_ack,
    input  logic               ba_rdy,
    input  logic [15:0]        data_read
);

    localparam int LAW_MS = (MAIN_AW > SND_AW) ? MAIN_AW : SND_AW;
    localparam int LAW    = (LAW_MS > PCM_AW) ? LAW_MS : PCM_AW;

    state_e            state_q, state_d;
    gnt_e              gnt_q, gnt_d;
    gnt_e              rr_q, rr_d;
    logic [LAW-1:0]    lat_q, lat_d;
    logic [21:0]       ba_addr_q, ba_addr_d;
    logic              ba_rd_q, ba_rd_d;
    logic              capture;

    logic [2:0]        pend;
    logic [LAW-1:0]    req_addr [3];
    logic [21:0]       req_wa   [3];
    gnt_e              c0, c1, c2, sel;
    logic              any;

    assign pend[GNT_MAIN] = main_cs & ~main_ok;
    assign pend[GNT_SND]  = snd_cs  & ~snd_ok;
    assign pend[GNT_PCM]  = pcm_cs  & ~pcm_ok;

    assign req_addr[GNT_MAIN] = LAW'(main_addr);
    assign req_addr[GNT_SND]  = LAW'(snd_addr);
    assign req_addr[GNT_PCM]  = LAW'(pcm_addr);

    // Offsets are word offsets; the sums wrap inside the 22-bit bank address.
    assign req_wa[GNT_MAIN] = 22'(main_addr[MAIN_AW-1:1]);
    assign req_wa[GNT_SND]  = SND_OFFSET + 22'(snd_addr[SND_AW-1:1]);
    assign req_wa[GNT_PCM]  = PCM_OFFSET + 22'(pcm_addr[PCM_AW-1:1]);

    always_comb begin
        c0  = rr_q;
        c1  = gnt_next(c0);
        c2  = gnt_next(c1);
        sel = c0;
        any = 1'b1;
        if (pend[c0])      sel = c0;
        else if (pend[c1]) sel = c1;
        else if (pend[c2]) sel = c2;
        else               any = 1'b0;
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        rr_d      = rr_q;
        lat_d     = lat_q;
        ba_addr_d = ba_addr_q;
        ba_rd_d   = ba_rd_q;
        capture   = 1'b0;
        case (state_q)
            IDLE: begin
                if (any) begin
                    gnt_d     = sel;
                    lat_d     = req_addr[sel];
                    ba_addr_d = req_wa[sel];
                    ba_rd_d   = 1'b1;
                    state_d   = ACK;
                end
            end
            ACK: begin
                if (ba_ack) begin
                    ba_rd_d = 1'b0;
                    // Data arriving with the ack completes the transfer at once.
                    if (ba_rdy) begin
                        capture = 1'b1;
                        rr_d    = gnt_next(gnt_q);
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (ba_rdy) begin
                    capture = 1'b1;
                    rr_d    = gnt_next(gnt_q);
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                ba_rd_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= GNT_MAIN;
            rr_q      <= GNT_MAIN;
            lat_q     <= '0;
            ba_addr_q <= '0;
            ba_rd_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            rr_q      <= rr_d;
            lat_q     <= lat_d;
            ba_addr_q <= ba_addr_d;
            ba_rd_q   <= ba_rd_d;
        end
    end

    assign ba_addr = ba_addr_q;
    assign ba_rd   = ba_rd_q;

    jtvigil_rom_slot #(.AW(MAIN_AW)) u_main (
        .clk     (clk),
        .rst     (rst),
        .cs      (main_cs),
        .addr    (main_addr),
        .wr      (capture && (gnt_q == GNT_MAIN)),
        .wr_addr (lat_q[MAIN_AW-1:0]),
        .wr_word (data_read),
        .data    (main_data),
        .ok      (main_ok)
    );

    jtvigil_rom_slot #(.AW(SND_AW)) u_snd (
        .clk     (clk),
        .rst     (rst),
        .cs      (snd_cs),
        .addr    (snd_addr),
        .wr      (capture && (gnt_q == GNT_SND)),
        .wr_addr (lat_q[SND_AW-1:0]),
        .wr_word (data_read),
        .data    (snd_data),
        .ok      (snd_ok)
    );

    jtvigil_rom_slot #(.AW(PCM_AW)) u_pcm (
        .clk     (clk),
        .rst     (rst),
        .cs      (pcm_cs),
        .addr    (pcm_addr),
        .wr      (capture && (gnt_q == GNT_PCM)),
        .wr_addr (lat_q[PCM_AW-1:0]),
        .wr_word (data_read),
        .data    (pcm_data),
        .ok      (pcm_ok)
    );

endmodule
